// File: rtl/rca_seq_pkg.sv
// ----------------------------------------------------------------------------
// rca_seq_pkg
// Shared definitions for the multi-precision word sequencer:
//   state_t : sequencer state encoding (IDLE, RUN, DONE)
//   idx_w   : width of the word-index register for a given word count
// ----------------------------------------------------------------------------
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index width is $clog2(words), but never less than one bit so that a
    // single-word build still has a legal index register.
    function automatic int idx_w(input int words);
        int w;
        w = $clog2(words);
        if (w < 1) begin
            w = 1;
        end else begin
            w = w;
        end
        return w;
    endfunction

endpackage

// File: rtl/rca_word_add.sv
// ----------------------------------------------------------------------------
// rca_word_add
// Combinational SIZE-bit ripple-carry adder built from per-bit full-adder cells.
// Ports:
//   a, b  in  [SIZE-1:0]  addends
//   cin   in  1           carry into bit 0
//   s     out [SIZE-1:0]  sum
//   co    out 1           carry out of bit SIZE-1
// ----------------------------------------------------------------------------
module rca_word_add #(
    parameter int SIZE = 4
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            cin,
    output logic [SIZE-1:0] s,
    output logic            co
);

    logic [SIZE:0] carry_s;

    assign carry_s[0] = cin;

    // One full-adder cell per bit; carry ripples from bit 0 upwards.
    for (genvar i = 0; i < SIZE; i++) begin : g_fa
        assign s[i]         = a[i] ^ b[i] ^ carry_s[i];
        assign carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
    end

    assign co = carry_s[SIZE];

endmodule

// File: rtl/rca_word_sequencer.sv
// ----------------------------------------------------------------------------
// rca_word_sequencer
// Adds two SIZE*WORDS-bit operands by running a single SIZE-bit ripple-carry
// word adder WORDS times, least-significant word first, with the inter-word
// carry held in a register. Valid/ready on both sides.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b  [W-1:0], cin   operands and carry-in, latched on accept
//   sub                  (only with RCA_WORD_SEQ_SUB_EN) 1 = compute a-b
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   sum [W-1:0], cout    result, held while out_valid=1
//   busy                 1 in RUN or DONE
// Configuration macro: RCA_WORD_SEQ_SUB_EN enables the subtract mode.
// ----------------------------------------------------------------------------
module rca_word_sequencer
    import rca_seq_pkg::*;
#(
    parameter int SIZE  = 4,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SIZE*WORDS-1:0] a,
    input  logic [SIZE*WORDS-1:0] b,
    input  logic                  cin,
`ifdef RCA_WORD_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SIZE*WORDS-1:0] sum,
    output logic                  cout,
    output logic                  busy
);

    localparam int W  = SIZE * WORDS;
    localparam int IW = idx_w(WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

    state_t          state_r;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [W-1:0]    sum_r;
    logic            carry_r;
    logic            cout_r;
    logic [IW-1:0]   idx_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic            busy_r;
`ifdef RCA_WORD_SEQ_SUB_EN
    logic            sub_r;
`endif

    int              base_s;
    logic [SIZE-1:0] a_word_s;
    logic [SIZE-1:0] b_word_s;
    logic [SIZE-1:0] s_word_s;
    logic            co_word_s;

    // Select the current word of each operand; in subtract mode b is inverted
    // so that a + ~b + 1 yields a - b.
    always_comb begin
        base_s   = int'(idx_r) * SIZE;
        a_word_s = a_r[base_s +: SIZE];
`ifdef RCA_WORD_SEQ_SUB_EN
        b_word_s = b_r[base_s +: SIZE] ^ {SIZE{sub_r}};
`else
        b_word_s = b_r[base_s +: SIZE];
`endif
    end

    rca_word_add #(
        .SIZE (SIZE)
    ) u_word_add (
        .a   (a_word_s),
        .b   (b_word_s),
        .cin (carry_r),
        .s   (s_word_s),
        .co  (co_word_s)
    );

    // Sequencer FSM: operand capture, one word per RUN cycle, result hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            idx_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
`ifdef RCA_WORD_SEQ_SUB_EN
            sub_r       <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        a_r        <= a;
                        b_r        <= b;
                        idx_r      <= '0;
`ifdef RCA_WORD_SEQ_SUB_EN
                        sub_r      <= sub;
                        // Subtraction needs the +1 of two's complement; cin is ignored.
                        carry_r    <= sub ? 1'b1 : cin;
`else
                        carry_r    <= cin;
`endif
                        state_r    <= RUN;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                RUN: begin
                    // Unwritten words keep their old contents; they are hidden
                    // behind out_valid=0 until the last word lands.
                    sum_r[base_s +: SIZE] <= s_word_s;
                    carry_r               <= co_word_s;
                    if (idx_r == LAST_IDX) begin
                        cout_r      <= co_word_s;
                        state_r     <= DONE;
                        out_valid_r <= 1'b1;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        idx_r       <= '0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    in_ready_r  <= 1'b1;
                    idx_r       <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign sum       = sum_r;
    assign cout      = cout_r;

endmodule
